// File: rtl/shift_sequencer_pkg.sv
// shift_seq_pkg: shared constants for the shift sequencer and the shift stage.
//   MODE_* : encodings of the shift stage ctrl input
//   state_t: sequencer FSM state encoding (3-bit)
package shift_seq_pkg;

  localparam logic [1:0] MODE_SHR = 2'b00;  // shift right, zero fill
  localparam logic [1:0] MODE_SHL = 2'b01;  // shift left, zero fill
  localparam logic [1:0] MODE_ROR = 2'b10;  // rotate right
  localparam logic [1:0] MODE_ROL = 2'b11;  // rotate left

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SHIFT = 3'd2,
    CAPT  = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/shift_sequencer_if.sv
// shift_sequencer_if: command and result handshake channels of the sequencer.
//   cmd_valid/cmd_ready with cmd_mode, cmd_count, cmd_data   (master -> slave)
//   res_valid/res_ready with res_data                        (slave -> master)
//   master: command producer / result consumer
//   slave : the sequencer
interface shift_sequencer_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_mode;
  logic [CNT_W-1:0] cmd_count;
  logic [WIDTH-1:0] cmd_data;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;

  modport master (
    output cmd_valid, cmd_mode, cmd_count, cmd_data, res_ready,
    input  cmd_ready, res_valid, res_data
  );

  modport slave (
    input  cmd_valid, cmd_mode, cmd_count, cmd_data, res_ready,
    output cmd_ready, res_valid, res_data
  );
endinterface

// File: rtl/shift_sequencer_stage.sv
// shift_sequencer_stage: 8-bit universal shift stage driven by the sequencer.
//   clk, rst (async active-low)
//   load : active-high, y takes d at the edge
//   ctrl : MODE_* operation applied each edge while load is low
//   d    : parallel load value
//   y    : registered stage output
module shift_sequencer_stage
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [1:0]       ctrl,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] y
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      y <= '0;
    end else if (load) begin
      y <= d;
    end else begin
      case (ctrl)
        MODE_SHR: y <= {1'b0, y[WIDTH-1:1]};
        MODE_SHL: y <= {y[WIDTH-2:0], 1'b0};
        MODE_ROR: y <= {y[0], y[WIDTH-1:1]};
        default:  y <= {y[WIDTH-2:0], y[WIDTH-1]};
      endcase
    end
  end

endmodule

// File: rtl/shift_sequencer.sv
// shift_sequencer: command-driven controller for the universal shift stage.
// Takes {mode, count, data}, loads data into the stage, holds the mode for
// exactly count shift edges, captures the stage output and returns it.
//   clk, rst   : clock, async active-low reset
//   bus        : command/result handshakes (slave side)
//   sh_load    : stage load (high everywhere except SHIFT)
//   sh_ctrl    : stage operation, mode during SHIFT, else 0
//   sh_d       : stage parallel input, command data during LOAD, else 0
//   sh_y       : stage output
//   busy       : high in every state except IDLE
//
// state | meaning
// IDLE  | waiting for a command, stage held in load
// LOAD  | stage takes the command data at the exit edge
// SHIFT | stage shifts one position per edge, count edges total
// CAPT  | stage re-enters load; result captured at the exit edge
// DONE  | result presented until res_ready
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              rst,
  shift_sequencer_if.slave  bus,
  output logic              sh_load,
  output logic [1:0]        sh_ctrl,
  output logic [WIDTH-1:0]  sh_d,
  input  logic [WIDTH-1:0]  sh_y,
  output logic              busy
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [1:0]       mode_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] res_q;
  logic             cmd_ready_c;
  logic             res_valid_c;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // The counter is loaded with count on accept and is already correct when
  // SHIFT is entered; it counts down to 1 and holds there.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q <= MODE_SHR;
      cnt_q  <= '0;
      data_q <= '0;
      res_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.cmd_valid) begin
            mode_q <= bus.cmd_mode;
            cnt_q  <= bus.cmd_count;
            data_q <= bus.cmd_data;
          end
        end
        SHIFT: begin
          if (cnt_q > CNT_ONE) begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        CAPT: begin
          res_q <= sh_y;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    sh_load     = 1'b1;
    sh_ctrl     = MODE_SHR;
    sh_d        = '0;
    cmd_ready_c = 1'b0;
    res_valid_c = 1'b0;
    busy        = 1'b1;
    case (state_q)
      IDLE: begin
        cmd_ready_c = 1'b1;
        busy        = 1'b0;
        if (bus.cmd_valid) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        sh_d    = data_q;
        state_d = (cnt_q != '0) ? SHIFT : CAPT;
      end
      SHIFT: begin
        sh_load = 1'b0;
        sh_ctrl = mode_q;
        if (cnt_q <= CNT_ONE) begin
          state_d = CAPT;
        end
      end
      CAPT: begin
        state_d = DONE;
      end
      DONE: begin
        res_valid_c = 1'b1;
        if (bus.res_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.cmd_ready = cmd_ready_c;
  assign bus.res_valid = res_valid_c;
  assign bus.res_data  = res_q;

endmodule

// File: tb/tb_shift_sequencer.sv
module tb_shift_sequencer;
  import shift_seq_pkg::*;

  localparam int WIDTH = 8;
  localparam int CNT_W = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  shift_sequencer_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  logic             sh_load;
  logic [1:0]       sh_ctrl;
  logic [WIDTH-1:0] sh_d;
  logic [WIDTH-1:0] sh_y;
  logic             busy;

  shift_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .sh_load (sh_load),
    .sh_ctrl (sh_ctrl),
    .sh_d    (sh_d),
    .sh_y    (sh_y),
    .busy    (busy)
  );

  shift_sequencer_stage #(.WIDTH(WIDTH)) stage (
    .clk  (clk),
    .rst  (rst),
    .load (sh_load),
    .ctrl (sh_ctrl),
    .d    (sh_d),
    .y    (sh_y)
  );

  typedef struct {
    logic [WIDTH-1:0] data;
    int               acc_cyc;
    int               cnt;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] model(input logic [1:0] m, input int c,
                                             input logic [WIDTH-1:0] d);
    logic [WIDTH-1:0] v;
    v = d;
    for (int i = 0; i < c; i++) begin
      case (m)
        2'b00:   v = v >> 1;
        2'b01:   v = v << 1;
        2'b10:   v = {v[0], v[WIDTH-1:1]};
        default: v = {v[WIDTH-2:0], v[WIDTH-1]};
      endcase
    end
    return v;
  endfunction

  // Result monitor: latency on each rising res_valid, data on each handshake.
  logic rv_prev = 1'b0;
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst) begin
      if (bus.res_valid && !rv_prev && sb.size() > 0)
        check_eq("latency", cyc - sb[0].acc_cyc, sb[0].cnt + 2);
      if (bus.res_valid && bus.res_ready) begin
        check_eq("sb_nonempty", (sb.size() > 0), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check_eq("res_data", bus.res_data, e.data);
        end
      end
    end
    rv_prev = bus.res_valid;
  end

  task automatic send(input logic [1:0] m, input int c, input logic [WIDTH-1:0] d,
                      input bit hold);
    exp_t e;
    int   k;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_mode  = m;
    bus.cmd_count = CNT_W'(c);
    bus.cmd_data  = d;
    k = 0;
    while (!bus.cmd_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) check_eq("cmd_accept_timeout", bus.cmd_ready, 1);
    @(posedge clk);
    #1;
    e.data    = model(m, c, d);
    e.acc_cyc = cyc;
    e.cnt     = c;
    sb.push_back(e);
    if (!hold) begin
      @(negedge clk);
      bus.cmd_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((sb.size() > 0 || bus.res_valid) && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (k >= 300) check_eq("drain_timeout", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]       bm[4];
    int               bc[4];
    logic [WIDTH-1:0] bd[4];
    int               k;

    bus.cmd_valid = 1'b0;
    bus.cmd_mode  = 2'b00;
    bus.cmd_count = '0;
    bus.cmd_data  = '0;
    bus.res_ready = 1'b1;

    repeat (3) @(negedge clk);
    check_eq("rst_cmd_ready", bus.cmd_ready, 1);
    check_eq("rst_res_valid", bus.res_valid, 0);
    check_eq("rst_res_data", bus.res_data, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_sh_load", sh_load, 1);
    check_eq("rst_sh_ctrl", sh_ctrl, 0);
    check_eq("rst_sh_d", sh_d, 0);
    rst = 1'b1;

    // Directed single commands, including count=0 and count=WIDTH-1.
    send(MODE_SHR, 3, 8'hAA, 1'b0); drain();
    send(MODE_SHL, 3, 8'hAA, 1'b0); drain();
    send(MODE_ROR, 1, 8'hAA, 1'b0); drain();
    send(MODE_ROL, 4, 8'hA5, 1'b0); drain();
    send(MODE_ROL, 0, 8'h3C, 1'b0); drain();
    send(MODE_ROR, 7, 8'h81, 1'b0); drain();

    // Backpressure with cmd_valid pulses while busy.
    bus.res_ready = 1'b0;
    send(MODE_ROL, 2, 8'h81, 1'b0);
    k = 0;
    while (!bus.res_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) check_eq("bp_valid_timeout", bus.res_valid, 1);
    for (int i = 0; i < 10; i++) begin
      check_eq("bp_res_valid", bus.res_valid, 1);
      check_eq("bp_res_data", bus.res_data, 8'h06);
      check_eq("bp_cmd_ready", bus.cmd_ready, 0);
      bus.cmd_valid = (i % 2 == 0);
      bus.cmd_mode  = MODE_SHL;
      bus.cmd_count = 3'd1;
      bus.cmd_data  = 8'hFF;
      @(negedge clk);
    end
    bus.cmd_valid = 1'b0;
    @(posedge clk);
    #1;
    bus.res_ready = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    check_eq("bp_post_cmd_ready", bus.cmd_ready, 1);
    check_eq("bp_post_busy", busy, 0);
    check_eq("bp_post_res_valid", bus.res_valid, 0);
    check_eq("bp_sb_empty", sb.size(), 0);

    // Reset in the middle of a count=7 shift.
    send(MODE_SHR, 7, 8'hFF, 1'b0);
    repeat (2) @(negedge clk);
    check_eq("pre_rst_busy", busy, 1);
    check_eq("pre_rst_sh_load", sh_load, 0);
    #2;
    rst = 1'b0;
    #1;
    check_eq("mid_rst_res_valid", bus.res_valid, 0);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_sh_load", sh_load, 1);
    check_eq("mid_rst_cmd_ready", bus.cmd_ready, 1);
    sb.delete();
    @(negedge clk);
    rst = 1'b1;
    send(MODE_SHL, 7, 8'h81, 1'b0); drain();

    // Back-to-back commands with cmd_valid held high.
    bm = '{MODE_SHR, MODE_ROL, MODE_SHL, MODE_ROR};
    bc = '{2, 5, 0, 6};
    bd = '{8'hF0, 8'h93, 8'h5A, 8'h0F};
    for (int i = 0; i < 4; i++) send(bm[i], bc[i], bd[i], (i < 3));
    drain();
    check_eq("b2b_sb_empty", sb.size(), 0);

    // Random commands.
    for (int i = 0; i < 8; i++)
      send(2'($urandom_range(3)), $urandom_range(7), 8'($urandom_range(255)), 1'b0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
